// File: rtl/l2_arb_pkg.sv
// Shared types and widths for the L2 request arbiter.
//   address_width   : byte address width
//   offset_width    : line offset bits (128 B lines)
//   line_width      : bits per cache line
//   line_addr_width : line address width seen on every request/address port
package l2_arb_pkg;

  localparam int unsigned address_width   = 32;
  localparam int unsigned offset_width    = 7;
  localparam int unsigned line_width      = 1024;
  localparam int unsigned line_addr_width = address_width - offset_width;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_I   = 2'd0,
    OWN_DRD = 2'd1,
    OWN_DWR = 2'd2
  } owner_t;

  // Write-back capture: victim line plus its line address.
  typedef struct packed {
    logic [line_width-1:0]      data;
    logic [line_addr_width-1:0] addr;
  } wb_payload_t;

  // Refill owners expect L2_RESP_VALID; the write-back owner expects L2_WR_ACK.
  function automatic logic is_read(input owner_t owner);
    return owner != OWN_DWR;
  endfunction

endpackage

// File: rtl/l2_request_arbiter_slot.sv
// l2_req_slot: one pending request source (flag + payload register).
//   CLK, RST      : clock, synchronous active-high reset
//   capture       : single-cycle request pulse from the requester
//   capture_data  : payload sampled with capture
//   clear         : request accepted by L2, drop the flag
//   in_service    : this source owns the in-flight L2 transaction
//   pending       : registered pending flag
//   payload       : registered payload
//   pending_nxt_c : next value of pending (lets the parent register BUSY)
//   dup_c         : pulse dropped because the source is already pending/in service
module l2_req_slot #(
  parameter int unsigned payload_width = 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     capture,
  input  logic [payload_width-1:0] capture_data,
  input  logic                     clear,
  input  logic                     in_service,
  output logic                     pending,
  output logic [payload_width-1:0] payload,
  output logic                     pending_nxt_c,
  output logic                     dup_c
);

  logic take;

  assign dup_c         = capture & (pending | in_service);
  assign take          = capture & ~dup_c;
  assign pending_nxt_c = take | (pending & ~clear);

  // Flag and payload; a dropped duplicate leaves the original payload intact.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending <= 1'b0;
      payload <= '0;
    end else begin
      pending <= pending_nxt_c;
      if (take) begin
        payload <= capture_data;
      end
    end
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter: shares the single L2 port between I-cache refills and
// D-cache refills/write-backs, one transaction outstanding at a time.
//   CLK, RST                       : clock, synchronous active-high reset
//   I_REQ_VALID/ADDR               : I-cache miss pulse and line address
//   I_DATA/I_DATA_VALID            : refill line and one-cycle valid to I-cache
//   D_RD_VALID/ADDR                : D-cache refill pulse and line address
//   D_WR_VALID/ADDR/DATA           : D-cache write-back pulse, address, line
//   D_DATA/D_DATA_VALID            : refill line and one-cycle valid to D-cache
//   D_WR_DONE                      : one-cycle write-back acknowledge
//   L2_REQ_VALID/READY/WRITE/ADDR/WDATA : request channel to L2
//   L2_RESP_VALID/DATA, L2_WR_ACK  : L2 responses
//   BUSY                           : FSM active or any request pending
//   PROTO_ERR                      : one-cycle pulse on protocol violation
module l2_request_arbiter
  import l2_arb_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       I_REQ_VALID,
  input  logic [line_addr_width-1:0] I_REQ_ADDR,
  output logic [line_width-1:0]      I_DATA,
  output logic                       I_DATA_VALID,
  input  logic                       D_RD_VALID,
  input  logic [line_addr_width-1:0] D_RD_ADDR,
  input  logic                       D_WR_VALID,
  input  logic [line_addr_width-1:0] D_WR_ADDR,
  input  logic [line_width-1:0]      D_WR_DATA,
  output logic [line_width-1:0]      D_DATA,
  output logic                       D_DATA_VALID,
  output logic                       D_WR_DONE,
  output logic                       L2_REQ_VALID,
  input  logic                       L2_REQ_READY,
  output logic                       L2_REQ_WRITE,
  output logic [line_addr_width-1:0] L2_REQ_ADDR,
  output logic [line_width-1:0]      L2_REQ_WDATA,
  input  logic                       L2_RESP_VALID,
  input  logic [line_width-1:0]      L2_RESP_DATA,
  input  logic                       L2_WR_ACK,
  output logic                       BUSY,
  output logic                       PROTO_ERR
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d, winner;
  logic   rr_favor_d_q, rr_favor_d_d;

  logic                       pend_i, pend_drd, pend_dwr;
  logic                       nxt_i, nxt_drd, nxt_dwr;
  logic                       dup_i, dup_drd, dup_dwr;
  logic                       clr_i, clr_drd, clr_dwr;
  logic                       svc_i, svc_drd, svc_dwr;
  logic [line_addr_width-1:0] pay_i, pay_drd;
  wb_payload_t                pay_dwr, wr_capture;

  logic d_pend, any_pend, pick_d, in_flight, accept;
  logic owner_is_read, resp_any, rd_done, wr_done;

  logic                       req_valid_d, req_write_d;
  logic [line_addr_width-1:0] req_addr_d;
  logic [line_width-1:0]      req_wdata_d, i_data_d, d_data_d;
  logic                       i_dv_d, d_dv_d, wr_done_d, proto_d, busy_d;

  assign wr_capture = '{data: D_WR_DATA, addr: D_WR_ADDR};

  // Transaction ownership and accept handshake drive the slots' service/clear.
  assign in_flight = (state_q != IDLE);
  assign accept    = (state_q == REQ) & L2_REQ_READY;
  assign svc_i     = in_flight & (owner_q == OWN_I);
  assign svc_drd   = in_flight & (owner_q == OWN_DRD);
  assign svc_dwr   = in_flight & (owner_q == OWN_DWR);
  assign clr_i     = accept & (owner_q == OWN_I);
  assign clr_drd   = accept & (owner_q == OWN_DRD);
  assign clr_dwr   = accept & (owner_q == OWN_DWR);

  l2_req_slot #(.payload_width(line_addr_width)) u_slot_i (
    .CLK          (CLK),
    .RST          (RST),
    .capture      (I_REQ_VALID),
    .capture_data (I_REQ_ADDR),
    .clear        (clr_i),
    .in_service   (svc_i),
    .pending      (pend_i),
    .payload      (pay_i),
    .pending_nxt_c(nxt_i),
    .dup_c        (dup_i)
  );

  l2_req_slot #(.payload_width(line_addr_width)) u_slot_drd (
    .CLK          (CLK),
    .RST          (RST),
    .capture      (D_RD_VALID),
    .capture_data (D_RD_ADDR),
    .clear        (clr_drd),
    .in_service   (svc_drd),
    .pending      (pend_drd),
    .payload      (pay_drd),
    .pending_nxt_c(nxt_drd),
    .dup_c        (dup_drd)
  );

  l2_req_slot #(.payload_width($bits(wb_payload_t))) u_slot_dwr (
    .CLK          (CLK),
    .RST          (RST),
    .capture      (D_WR_VALID),
    .capture_data (wr_capture),
    .clear        (clr_dwr),
    .in_service   (svc_dwr),
    .pending      (pend_dwr),
    .payload      (pay_dwr),
    .pending_nxt_c(nxt_dwr),
    .dup_c        (dup_dwr)
  );

  // D class is the write-back if present (victim leaves before refill), else the refill.
  assign d_pend   = pend_dwr | pend_drd;
  assign any_pend = d_pend | pend_i;
  assign pick_d   = d_pend & (~pend_i | rr_favor_d_q);

  always_comb begin
    winner = OWN_I;
    if (pick_d) begin
      winner = pend_dwr ? OWN_DWR : OWN_DRD;
    end
  end

  assign owner_is_read = is_read(owner_q);
  assign resp_any      = L2_RESP_VALID | L2_WR_ACK;
  assign rd_done       = (state_q == WAIT) & L2_RESP_VALID & owner_is_read;
  assign wr_done       = (state_q == WAIT) & L2_WR_ACK & ~owner_is_read;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = REQ;
      REQ:     if (L2_REQ_READY) state_d = WAIT;
      WAIT:    if (rd_done | wr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values for every registered output.
  always_comb begin
    req_valid_d  = L2_REQ_VALID;
    req_write_d  = L2_REQ_WRITE;
    req_addr_d   = L2_REQ_ADDR;
    req_wdata_d  = L2_REQ_WDATA;
    owner_d      = owner_q;
    rr_favor_d_d = rr_favor_d_q;
    i_data_d     = I_DATA;
    d_data_d     = D_DATA;
    i_dv_d       = 1'b0;
    d_dv_d       = 1'b0;
    wr_done_d    = 1'b0;
    proto_d      = dup_i | dup_drd | dup_dwr;
    busy_d       = (state_d != IDLE) | nxt_i | nxt_drd | nxt_dwr;

    case (state_q)
      IDLE: begin
        if (resp_any) proto_d = 1'b1;
        if (any_pend) begin
          req_valid_d  = 1'b1;
          owner_d      = winner;
          rr_favor_d_d = (winner == OWN_I);
          case (winner)
            OWN_DWR: begin
              req_write_d = 1'b1;
              req_addr_d  = pay_dwr.addr;
              req_wdata_d = pay_dwr.data;
            end
            OWN_DRD: begin
              req_write_d = 1'b0;
              req_addr_d  = pay_drd;
              req_wdata_d = '0;
            end
            default: begin
              req_write_d = 1'b0;
              req_addr_d  = pay_i;
              req_wdata_d = '0;
            end
          endcase
        end
      end
      REQ: begin
        if (resp_any) proto_d = 1'b1;
        if (L2_REQ_READY) req_valid_d = 1'b0;
      end
      WAIT: begin
        if (L2_RESP_VALID) begin
          if (!owner_is_read) begin
            proto_d = 1'b1;
          end else if (owner_q == OWN_I) begin
            i_data_d = L2_RESP_DATA;
            i_dv_d   = 1'b1;
          end else begin
            d_data_d = L2_RESP_DATA;
            d_dv_d   = 1'b1;
          end
        end
        if (L2_WR_ACK) begin
          if (owner_is_read) begin
            proto_d = 1'b1;
          end else begin
            wr_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Output and bookkeeping registers; pointer resets favouring the D class.
  always_ff @(posedge CLK) begin
    if (RST) begin
      L2_REQ_VALID <= 1'b0;
      L2_REQ_WRITE <= 1'b0;
      L2_REQ_ADDR  <= '0;
      L2_REQ_WDATA <= '0;
      owner_q      <= OWN_I;
      rr_favor_d_q <= 1'b1;
      I_DATA       <= '0;
      D_DATA       <= '0;
      I_DATA_VALID <= 1'b0;
      D_DATA_VALID <= 1'b0;
      D_WR_DONE    <= 1'b0;
      PROTO_ERR    <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      L2_REQ_VALID <= req_valid_d;
      L2_REQ_WRITE <= req_write_d;
      L2_REQ_ADDR  <= req_addr_d;
      L2_REQ_WDATA <= req_wdata_d;
      owner_q      <= owner_d;
      rr_favor_d_q <= rr_favor_d_d;
      I_DATA       <= i_data_d;
      D_DATA       <= d_data_d;
      I_DATA_VALID <= i_dv_d;
      D_DATA_VALID <= d_dv_d;
      D_WR_DONE    <= wr_done_d;
      PROTO_ERR    <= proto_d;
      BUSY         <= busy_d;
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter: per-request vector table plus
// hand-written sequences for eviction ordering, fairness, errors and reset.
module tb_l2_request_arbiter;
  import l2_arb_pkg::*;

  localparam int unsigned aw = line_addr_width;
  localparam int unsigned lw = line_width;
  localparam int K_I   = 0;
  localparam int K_DRD = 1;
  localparam int K_DWR = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          I_REQ_VALID;
  logic [aw-1:0] I_REQ_ADDR;
  logic [lw-1:0] I_DATA;
  logic          I_DATA_VALID;
  logic          D_RD_VALID;
  logic [aw-1:0] D_RD_ADDR;
  logic          D_WR_VALID;
  logic [aw-1:0] D_WR_ADDR;
  logic [lw-1:0] D_WR_DATA;
  logic [lw-1:0] D_DATA;
  logic          D_DATA_VALID;
  logic          D_WR_DONE;
  logic          L2_REQ_VALID;
  logic          L2_REQ_READY;
  logic          L2_REQ_WRITE;
  logic [aw-1:0] L2_REQ_ADDR;
  logic [lw-1:0] L2_REQ_WDATA;
  logic          L2_RESP_VALID;
  logic [lw-1:0] L2_RESP_DATA;
  logic          L2_WR_ACK;
  logic          BUSY;
  logic          PROTO_ERR;

  always #5 CLK = ~CLK;

  l2_request_arbiter dut (
    .CLK          (CLK),
    .RST          (RST),
    .I_REQ_VALID  (I_REQ_VALID),
    .I_REQ_ADDR   (I_REQ_ADDR),
    .I_DATA       (I_DATA),
    .I_DATA_VALID (I_DATA_VALID),
    .D_RD_VALID   (D_RD_VALID),
    .D_RD_ADDR    (D_RD_ADDR),
    .D_WR_VALID   (D_WR_VALID),
    .D_WR_ADDR    (D_WR_ADDR),
    .D_WR_DATA    (D_WR_DATA),
    .D_DATA       (D_DATA),
    .D_DATA_VALID (D_DATA_VALID),
    .D_WR_DONE    (D_WR_DONE),
    .L2_REQ_VALID (L2_REQ_VALID),
    .L2_REQ_READY (L2_REQ_READY),
    .L2_REQ_WRITE (L2_REQ_WRITE),
    .L2_REQ_ADDR  (L2_REQ_ADDR),
    .L2_REQ_WDATA (L2_REQ_WDATA),
    .L2_RESP_VALID(L2_RESP_VALID),
    .L2_RESP_DATA (L2_RESP_DATA),
    .L2_WR_ACK    (L2_WR_ACK),
    .BUSY         (BUSY),
    .PROTO_ERR    (PROTO_ERR)
  );

  typedef struct {
    int            kind;
    logic [aw-1:0] addr;
    logic [31:0]   seed;
    int            ready_lag;
    int            resp_lag;
    logic          exp_write;
    logic          exp_i_dv;
    logic          exp_d_dv;
    logic          exp_done;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  logic [lw-1:0] exp_i_data;
  logic [lw-1:0] exp_d_data;
  vec_t          vecs[5];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [lw-1:0] act, input logic [lw-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got ..%016h want ..%016h", name, act[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [lw-1:0] mk_line(input logic [31:0] seed);
    logic [lw-1:0] l;
    for (int i = 0; i < 32; i++) l[i*32 +: 32] = seed + 32'(i);
    return l;
  endfunction

  task automatic quiet_inputs();
    I_REQ_VALID   = 1'b0;
    D_RD_VALID    = 1'b0;
    D_WR_VALID    = 1'b0;
    L2_RESP_VALID = 1'b0;
    L2_WR_ACK     = 1'b0;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    quiet_inputs();
    L2_REQ_READY = 1'b0;
    step();
    step();
    RST = 1'b0;
    exp_i_data = '0;
    exp_d_data = '0;
  endtask

  // One isolated request: latency, request fields, hold under backpressure, routing.
  task automatic run_vec(input vec_t v);
    logic [lw-1:0] wline;
    logic [lw-1:0] rline;
    wline = (v.kind == K_DWR) ? mk_line(v.seed) : '0;
    rline = mk_line(~v.seed);
    L2_REQ_READY = 1'b0;
    case (v.kind)
      K_I:     begin I_REQ_VALID = 1'b1; I_REQ_ADDR = v.addr; end
      K_DRD:   begin D_RD_VALID = 1'b1; D_RD_ADDR = v.addr; end
      default: begin D_WR_VALID = 1'b1; D_WR_ADDR = v.addr; D_WR_DATA = wline; end
    endcase
    step();
    quiet_inputs();
    chk("vec_valid_t1", 64'(L2_REQ_VALID), 64'(0));
    chk("vec_busy_t1", 64'(BUSY), 64'(1));
    step();
    chk("vec_valid_t2", 64'(L2_REQ_VALID), 64'(1));
    chk("vec_write", 64'(L2_REQ_WRITE), 64'(v.exp_write));
    chk("vec_addr", 64'(L2_REQ_ADDR), 64'(v.addr));
    chk_line("vec_wdata", L2_REQ_WDATA, wline);
    for (int i = 0; i < v.ready_lag; i++) begin
      step();
      chk("hold_valid", 64'(L2_REQ_VALID), 64'(1));
      chk("hold_addr", 64'(L2_REQ_ADDR), 64'(v.addr));
      chk("hold_write", 64'(L2_REQ_WRITE), 64'(v.exp_write));
      chk_line("hold_wdata", L2_REQ_WDATA, wline);
    end
    L2_REQ_READY = 1'b1;
    step();
    L2_REQ_READY = 1'b0;
    chk("vec_valid_after_accept", 64'(L2_REQ_VALID), 64'(0));
    for (int i = 0; i < v.resp_lag; i++) begin
      step();
      chk("vec_no_reissue", 64'(L2_REQ_VALID), 64'(0));
    end
    if (v.exp_write) begin
      L2_WR_ACK = 1'b1;
    end else begin
      L2_RESP_VALID = 1'b1;
      L2_RESP_DATA  = rline;
    end
    step();
    quiet_inputs();
    if (v.exp_i_dv) exp_i_data = rline;
    if (v.exp_d_dv) exp_d_data = rline;
    chk("vec_i_dv", 64'(I_DATA_VALID), 64'(v.exp_i_dv));
    chk("vec_d_dv", 64'(D_DATA_VALID), 64'(v.exp_d_dv));
    chk("vec_wr_done", 64'(D_WR_DONE), 64'(v.exp_done));
    chk("vec_proto", 64'(PROTO_ERR), 64'(0));
    chk_line("vec_i_data", I_DATA, exp_i_data);
    chk_line("vec_d_data", D_DATA, exp_d_data);
    step();
    chk("vec_pulses_end", 64'({I_DATA_VALID, D_DATA_VALID, D_WR_DONE}), 64'(0));
    chk("vec_busy_end", 64'(BUSY), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [lw-1:0] wl;
    logic [lw-1:0] rl;
    int            n;
    int            pulses;
    logic          exp_d;

    I_REQ_ADDR   = '0;
    D_RD_ADDR    = '0;
    D_WR_ADDR    = '0;
    D_WR_DATA    = '0;
    L2_RESP_DATA = '0;
    apply_reset();
    RST = 1'b1;
    step();
    chk("rst_outputs", 64'({L2_REQ_VALID, L2_REQ_WRITE, BUSY, PROTO_ERR,
                            I_DATA_VALID, D_DATA_VALID, D_WR_DONE}), 64'(0));
    chk("rst_addr", 64'(L2_REQ_ADDR), 64'(0));
    chk_line("rst_i_data", I_DATA, '0);
    RST = 1'b0;
    step();

    // kind, addr, seed, ready_lag, resp_lag, write, i_dv, d_dv, done
    vecs[0] = '{K_I,   25'h0123456, 32'h11110000, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{K_DRD, 25'h0000CD0, 32'h22220000, 2, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{K_DWR, 25'h0000AB0, 32'h33330000, 5, 2, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{K_I,   25'h1FFFFFF, 32'h44440000, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{K_DWR, 25'h0000000, 32'h55550000, 0, 0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i]);
      step();
    end

    // Dirty eviction: write-back and refill pulsed together, write-back first.
    wl = mk_line(32'hABAB0000);
    rl = mk_line(32'hCDCD0000);
    L2_REQ_READY = 1'b1;
    D_WR_VALID = 1'b1; D_WR_ADDR = 25'h0000AB0; D_WR_DATA = wl;
    D_RD_VALID = 1'b1; D_RD_ADDR = 25'h0000CD0;
    step();
    quiet_inputs();
    step();
    chk("evict_wb_valid", 64'(L2_REQ_VALID), 64'(1));
    chk("evict_wb_write", 64'(L2_REQ_WRITE), 64'(1));
    chk("evict_wb_addr", 64'(L2_REQ_ADDR), 64'(25'h0000AB0));
    chk_line("evict_wb_wdata", L2_REQ_WDATA, wl);
    step();
    chk("evict_wait_valid", 64'(L2_REQ_VALID), 64'(0));
    L2_WR_ACK = 1'b1;
    step();
    quiet_inputs();
    chk("evict_wr_done", 64'(D_WR_DONE), 64'(1));
    chk("evict_no_d_dv", 64'(D_DATA_VALID), 64'(0));
    chk("evict_idle_gap", 64'(L2_REQ_VALID), 64'(0));
    step();
    chk("evict_rd_valid", 64'(L2_REQ_VALID), 64'(1));
    chk("evict_rd_write", 64'(L2_REQ_WRITE), 64'(0));
    chk("evict_rd_addr", 64'(L2_REQ_ADDR), 64'(25'h0000CD0));
    chk("evict_done_once", 64'(D_WR_DONE), 64'(0));
    step();
    L2_RESP_VALID = 1'b1; L2_RESP_DATA = rl;
    step();
    quiet_inputs();
    exp_d_data = rl;
    chk("evict_d_dv", 64'(D_DATA_VALID), 64'(1));
    chk("evict_i_dv", 64'(I_DATA_VALID), 64'(0));
    chk_line("evict_d_data", D_DATA, exp_d_data);
    step();
    chk("evict_busy_end", 64'(BUSY), 64'(0));

    // Fairness: I and D refill kept pending, grants alternate starting with D.
    apply_reset();
    L2_REQ_READY = 1'b1;
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 25'h0000100;
    D_RD_VALID  = 1'b1; D_RD_ADDR  = 25'h0000200;
    step();
    quiet_inputs();
    for (int k = 0; k < 8; k++) begin
      exp_d = (k % 2 == 0);
      n = 0;
      while (!L2_REQ_VALID && n < 20) begin
        step();
        n++;
      end
      chk("fair_grant_valid", 64'(L2_REQ_VALID), 64'(1));
      chk("fair_grant_addr", 64'(L2_REQ_ADDR), exp_d ? 64'(25'h0000200) : 64'(25'h0000100));
      step();
      L2_RESP_VALID = 1'b1; L2_RESP_DATA = mk_line(32'(k));
      step();
      quiet_inputs();
      chk("fair_route", 64'({I_DATA_VALID, D_DATA_VALID}), exp_d ? 64'(1) : 64'(2));
      if (exp_d) D_RD_VALID = 1'b1;
      else       I_REQ_VALID = 1'b1;
      step();
      quiet_inputs();
    end

    // Protocol errors: stray response, duplicate pulse, wrong response kind.
    apply_reset();
    L2_RESP_VALID = 1'b1; L2_RESP_DATA = mk_line(32'hDEAD0000);
    step();
    quiet_inputs();
    chk("err_idle_resp_proto", 64'(PROTO_ERR), 64'(1));
    chk("err_idle_resp_nodata", 64'({I_DATA_VALID, D_DATA_VALID}), 64'(0));
    step();
    chk("err_proto_one_cycle", 64'(PROTO_ERR), 64'(0));
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 25'h0000555;
    step();
    I_REQ_ADDR = 25'h0000777;
    step();
    quiet_inputs();
    chk("err_dup_proto", 64'(PROTO_ERR), 64'(1));
    chk("err_dup_valid", 64'(L2_REQ_VALID), 64'(1));
    chk("err_dup_addr_kept", 64'(L2_REQ_ADDR), 64'(25'h0000555));
    L2_REQ_READY = 1'b1;
    step();
    L2_REQ_READY = 1'b0;
    L2_WR_ACK = 1'b1;
    step();
    quiet_inputs();
    chk("err_wrong_kind_proto", 64'(PROTO_ERR), 64'(1));
    chk("err_wrong_kind_done", 64'(D_WR_DONE), 64'(0));
    chk("err_wrong_kind_busy", 64'(BUSY), 64'(1));
    rl = mk_line(32'h55500000);
    L2_RESP_VALID = 1'b1; L2_RESP_DATA = rl;
    step();
    quiet_inputs();
    exp_i_data = rl;
    chk("err_i_dv", 64'(I_DATA_VALID), 64'(1));
    chk_line("err_i_data", I_DATA, exp_i_data);
    pulses = 0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      pulses += int'(I_DATA_VALID);
      n += int'(L2_REQ_VALID);
    end
    chk("err_single_completion", 64'(pulses), 64'(0));
    chk("err_no_reissue", 64'(n), 64'(0));
    chk("err_busy_end", 64'(BUSY), 64'(0));

    // Reset while waiting for a refill; the late response is a stray.
    L2_REQ_READY = 1'b1;
    I_REQ_VALID = 1'b1; I_REQ_ADDR = 25'h0000999;
    step();
    quiet_inputs();
    step();
    chk("rstw_req_valid", 64'(L2_REQ_VALID), 64'(1));
    step();
    L2_REQ_READY = 1'b0;
    chk("rstw_in_wait_busy", 64'(BUSY), 64'(1));
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_i_data = '0;
    chk("rstw_busy_clear", 64'(BUSY), 64'(0));
    chk("rstw_valid_clear", 64'(L2_REQ_VALID), 64'(0));
    chk_line("rstw_i_data_clear", I_DATA, exp_i_data);
    step();
    L2_RESP_VALID = 1'b1; L2_RESP_DATA = mk_line(32'h99900000);
    step();
    quiet_inputs();
    chk("rstw_late_proto", 64'(PROTO_ERR), 64'(1));
    chk("rstw_late_nodata", 64'({I_DATA_VALID, D_DATA_VALID}), 64'(0));
    chk("rstw_late_busy", 64'(BUSY), 64'(0));
    chk("rstw_late_valid", 64'(L2_REQ_VALID), 64'(0));
    step();
    chk("rstw_proto_end", 64'(PROTO_ERR), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Shares the single L2 refill port between the instruction cache and the data cache.
- I-side: line-refill requests only. D-side: line refills and dirty-line write-backs.
- Latches single-cycle request pulses and arbitrates round-robin between I and D. D write-back always goes before D read.
- Keeps exactly one L2 transaction outstanding and routes each response back to the requester that owns it.

Parameters:
- address_width, 32, byte address width.
- offset_width, 7, line offset bits (32 words x 32 bits = 128 B); line address width = address_width - offset_width.
- line_width, 1024, bits per cache line.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- I_REQ_VALID  in  1  I-cache miss pulse (one cycle)
- I_REQ_ADDR  in  address_width-offset_width  I-cache line address
- I_DATA  out  line_width  refill line to I-cache
- I_DATA_VALID  out  1  one-cycle pulse, I_DATA valid
- D_RD_VALID  in  1  D-cache refill pulse
- D_RD_ADDR  in  address_width-offset_width  D refill line address
- D_WR_VALID  in  1  D-cache write-back pulse
- D_WR_ADDR  in  address_width-offset_width  write-back line address
- D_WR_DATA  in  line_width  write-back line, sampled with D_WR_VALID
- D_DATA  out  line_width  refill line to D-cache
- D_DATA_VALID  out  1  one-cycle pulse, D_DATA valid
- D_WR_DONE  out  1  one-cycle pulse, write-back acknowledged
- L2_REQ_VALID  out  1  request to L2
- L2_REQ_READY  in  1  L2 accepts the request when VALID&READY
- L2_REQ_WRITE  out  1  1 = write-back, 0 = refill
- L2_REQ_ADDR  out  address_width-offset_width  line address
- L2_REQ_WDATA  out  line_width  write-back data
- L2_RESP_VALID  in  1  refill data valid
- L2_RESP_DATA  in  line_width  refill line
- L2_WR_ACK  in  1  write-back complete
- BUSY  out  1  FSM not IDLE or any request pending
- PROTO_ERR  out  1  one-cycle pulse on protocol violation

Behaviour:
- Reset values: all outputs 0; pending flags 0; FSM IDLE; round-robin pointer favours D.
- Pending capture: each of the three sources has a pending flag plus an address register (D_WR also holds data). A pulse sets the flag at the next edge.
- A pulse arriving while the same source is already pending (or in service) is dropped and raises PROTO_ERR.
- FSM states:
  - IDLE: if any flag is set, choose a winner, load L2_REQ_* registers, go to REQ.
  - REQ: L2_REQ_VALID=1; outputs held stable until L2_REQ_READY. On the accept edge, clear the winner's pending flag and go to WAIT.
  - WAIT: wait for the response, then go to IDLE.
- Arbitration in IDLE: D class = D_WR if pending, else D_RD. D_WR always beats D_RD so the victim is written back before the refill.
- Between the D class and I: round-robin. Pointer toggles to the other class after each grant.
- Latency: pulse at cycle t → flag set at t+1 → IDLE decides at t+1 → L2_REQ_VALID high from t+2 at the earliest.
- Refill response: L2_RESP_VALID in WAIT registers L2_RESP_DATA into the owner's I_DATA/D_DATA. The owner's *_DATA_VALID pulses high for exactly the next cycle. FSM enters IDLE on the same edge.
- *_DATA holds its value until the next refill to that side.
- Write-back response: L2_WR_ACK in WAIT with a write transaction → D_WR_DONE pulses the next cycle; go to IDLE.
- Wrong response kind for the in-flight transaction: ignored, PROTO_ERR, stay in WAIT.
- Response in IDLE/REQ: ignored, PROTO_ERR.
- New pulses are captured in every state, including during responses.
- Back-to-back: the grant after returning to IDLE happens the following cycle. There is a minimum of 1 idle cycle between L2 transactions.
- Reset mid-transaction: all flags and the FSM clear at once. Any L2 response after reset arrives in IDLE and is dropped with PROTO_ERR.
- Requesters are not re-notified after a mid-transaction reset; they reset together with the arbiter.

Decomposition:
- Shared package (l2_arb_pkg): FSM state encoding (IDLE/REQ/WAIT), owner encoding (OWN_I, OWN_DRD, OWN_DWR), and the line-address width constant derived from address_width/offset_width.
- One sub-module: l2_req_slot, instantiated three times. It is a pending flag plus address/data register with set-on-pulse, clear-on-grant and duplicate-detect.

Test Plan:
- Lone I miss: I_REQ_VALID at t=10, addr 0x0123456, L2_REQ_READY tied 1, L2_RESP_VALID 3 cycles after accept → L2_REQ_VALID at 12 with WRITE=0, I_DATA_VALID one cycle after the response with data matching, D outputs quiet.
- Dirty eviction: D_WR_VALID and D_RD_VALID in the same cycle (write addr 0x0000AB0, read addr 0x0000CD0) → write-back issued first, D_WR_DONE after L2_WR_ACK, then refill issued, D_DATA_VALID after its response.
- Fairness: I and D_RD pending together and re-requested continuously, 8 transactions → grants alternate D, I, D, I… and no source waits more than one other transaction.
- Backpressure: L2_REQ_READY low for 5 cycles → L2_REQ_VALID/ADDR/WRITE/WDATA held constant, accepted on the first READY=1 cycle, and no duplicate issue.
- Errors: L2_RESP_VALID in IDLE, and a second I_REQ_VALID while I is pending → PROTO_ERR pulse each time; no data pulse; the original I request completes once.
- Reset mid-WAIT: RST during WAIT, then L2_RESP_VALID 2 cycles later → FSM IDLE, BUSY=0, no I/D_DATA_VALID, PROTO_ERR pulse.
